// File: rtl/npc_bus_pkg.sv
// Shared bus definitions for the core memory port: FSM encodings, master ids, default widths.
package npc_bus_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_MASK_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IFU = 1'b0,
    GNT_LSU = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of IFU, LSU and slave handshakes around the shared memory port.
interface mem_port_arbiter_if
  import npc_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned MASK_W = DEF_MASK_W
);

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_req_addr;
  logic              ifu_resp_valid;
  logic              ifu_resp_ready;
  logic [DATA_W-1:0] ifu_resp_rdata;
  logic              ifu_resp_err;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic              lsu_req_wen;
  logic [DATA_W-1:0] lsu_req_wdata;
  logic [MASK_W-1:0] lsu_req_wmask;
  logic              lsu_resp_valid;
  logic              lsu_resp_ready;
  logic [DATA_W-1:0] lsu_resp_rdata;
  logic              lsu_resp_err;

  logic              s_req_valid;
  logic              s_req_ready;
  logic [ADDR_W-1:0] s_req_addr;
  logic              s_req_wen;
  logic [DATA_W-1:0] s_req_wdata;
  logic [MASK_W-1:0] s_req_wmask;
  logic              s_resp_valid;
  logic              s_resp_ready;
  logic [DATA_W-1:0] s_resp_rdata;
  logic              s_resp_err;

  // Arbiter view.
  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask, lsu_resp_ready,
    input  s_req_ready, s_resp_valid, s_resp_rdata, s_resp_err,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_rdata, ifu_resp_err,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
    output s_req_valid, s_req_addr, s_req_wen, s_req_wdata, s_req_wmask, s_resp_ready
  );

  // Requesters-plus-memory view.
  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask, lsu_resp_ready,
    output s_req_ready, s_resp_valid, s_resp_rdata, s_resp_err,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_rdata, ifu_resp_err,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
    input  s_req_valid, s_req_addr, s_req_wen, s_req_wdata, s_req_wmask, s_resp_ready
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not granted last.
module rr_arb2
  import npc_bus_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  gnt_e last_grant,
  output logic grant_valid,
  output gnt_e grant
);

  // Combinational winner selection.
  always_comb begin
    grant_valid = req0 | req1;
    grant       = GNT_IFU;
    if (req0 && req1) begin
      grant = (last_grant == GNT_IFU) ? GNT_LSU : GNT_IFU;
    end else if (req1) begin
      grant = GNT_LSU;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between IFU and LSU, one outstanding transaction at a time.
module mem_port_arbiter
  import npc_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned MASK_W = DEF_MASK_W
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } req_t;

  state_e state_q, state_d;
  gnt_e   grant_q, grant_d;   // doubles as last_grant for the round-robin
  req_t   req_q, req_d;
  logic   s_req_valid_q, s_req_valid_d;
  logic   arb_valid;
  gnt_e   arb_grant;

  rr_arb2 u_arb (
    .req0        (bus.ifu_req_valid),
    .req1        (bus.lsu_req_valid),
    .last_grant  (grant_q),
    .grant_valid (arb_valid),
    .grant       (arb_grant)
  );

  // State, grant and latched request payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= GNT_IFU;
      req_q         <= '0;
      s_req_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      req_q         <= req_d;
      s_req_valid_q <= s_req_valid_d;
    end
  end

  // Next state, grant/latch in IDLE, response routing in RESP.
  always_comb begin
    state_d            = state_q;
    grant_d            = grant_q;
    req_d              = req_q;
    s_req_valid_d      = 1'b0;
    bus.ifu_req_ready  = 1'b0;
    bus.lsu_req_ready  = 1'b0;
    bus.ifu_resp_valid = 1'b0;
    bus.ifu_resp_rdata = '0;
    bus.ifu_resp_err   = 1'b0;
    bus.lsu_resp_valid = 1'b0;
    bus.lsu_resp_rdata = '0;
    bus.lsu_resp_err   = 1'b0;
    bus.s_resp_ready   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid && !rst) begin
          grant_d       = arb_grant;
          state_d       = ST_REQ;
          s_req_valid_d = 1'b1;
          if (arb_grant == GNT_LSU) begin
            bus.lsu_req_ready = 1'b1;
            req_d.addr        = bus.lsu_req_addr;
            req_d.wen         = bus.lsu_req_wen;
            req_d.wdata       = bus.lsu_req_wdata;
            req_d.wmask       = bus.lsu_req_wmask;
          end else begin
            bus.ifu_req_ready = 1'b1;
            req_d.addr        = bus.ifu_req_addr;
            req_d.wen         = 1'b0;
            req_d.wdata       = '0;
            req_d.wmask       = '0;
          end
        end
      end
      ST_REQ: begin
        s_req_valid_d = 1'b1;
        if (bus.s_req_ready) begin
          s_req_valid_d = 1'b0;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (grant_q == GNT_IFU) begin
          bus.ifu_resp_valid = bus.s_resp_valid;
          bus.ifu_resp_rdata = bus.s_resp_rdata;
          bus.ifu_resp_err   = bus.s_resp_err;
          bus.s_resp_ready   = bus.ifu_resp_ready;
        end else begin
          bus.lsu_resp_valid = bus.s_resp_valid;
          bus.lsu_resp_rdata = bus.s_resp_rdata;
          bus.lsu_resp_err   = bus.s_resp_err;
          bus.s_resp_ready   = bus.lsu_resp_ready;
        end
        if (bus.s_resp_valid && bus.s_resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.s_req_valid = s_req_valid_q;
  assign bus.s_req_addr  = req_q.addr;
  assign bus.s_req_wen   = req_q.wen;
  assign bus.s_req_wdata = req_q.wdata;
  assign bus.s_req_wmask = req_q.wmask;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected slave requests and master
// responses into queues; a monitor pops and compares on every handshake.
module tb_mem_port_arbiter;
  import npc_bus_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [7:0]  wmask;
  } req_exp_t;

  typedef struct packed {
    logic        who;
    logic [31:0] rdata;
    logic        err;
  } resp_exp_t;

  req_exp_t  req_q[$];
  resp_exp_t resp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic mon_resp(input logic who, input logic [31:0] rdata, input logic err);
    resp_exp_t r;
    if (resp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL resp_unexpected: got response on master %0d, expected none", who);
    end else begin
      r = resp_q.pop_front();
      chk("resp_who", 32'(who), 32'(r.who));
      chk("resp_rdata", rdata, r.rdata);
      chk("resp_err", 32'(err), 32'(r.err));
    end
  endtask

  // Monitor: compares every slave-request and master-response handshake against the queues.
  initial begin : monitor
    req_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.s_req_valid && bus.s_req_ready) begin
          if (req_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL s_req_unexpected: got addr 0x%08h, expected no request", bus.s_req_addr);
          end else begin
            e = req_q.pop_front();
            chk("s_req_addr", bus.s_req_addr, e.addr);
            chk("s_req_wen", 32'(bus.s_req_wen), 32'(e.wen));
            chk("s_req_wdata", bus.s_req_wdata, e.wdata);
            chk("s_req_wmask", 32'(bus.s_req_wmask), 32'(e.wmask));
          end
        end
        if (bus.ifu_resp_valid && bus.ifu_resp_ready)
          mon_resp(1'b0, bus.ifu_resp_rdata, bus.ifu_resp_err);
        if (bus.lsu_resp_valid && bus.lsu_resp_ready)
          mon_resp(1'b1, bus.lsu_resp_rdata, bus.lsu_resp_err);
        if (bus.ifu_resp_valid && bus.lsu_resp_valid) begin
          n_vec++;
          n_err++;
          $display("FAIL dual_resp: got both resp_valid high, expected at most one");
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  // Advance one cycle from a negedge; drop any request valid that was accepted.
  task automatic adv();
    logic ai, al;
    ai = bus.ifu_req_valid && bus.ifu_req_ready;
    al = bus.lsu_req_valid && bus.lsu_req_ready;
    @(posedge clk);
    #1;
    if (ai) bus.ifu_req_valid = 1'b0;
    if (al) bus.lsu_req_valid = 1'b0;
  endtask

  task automatic drive_idle();
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_req_addr   = '0;
    bus.ifu_resp_ready = 1'b1;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_req_addr   = '0;
    bus.lsu_req_wen    = 1'b0;
    bus.lsu_req_wdata  = '0;
    bus.lsu_req_wmask  = '0;
    bus.lsu_resp_ready = 1'b1;
    bus.s_req_ready    = 1'b1;
    bus.s_resp_valid   = 1'b1;
    bus.s_resp_rdata   = '0;
    bus.s_resp_err     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic issue_ifu(input logic [31:0] addr);
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = addr;
    req_q.push_back('{addr: addr, wen: 1'b0, wdata: 32'h0, wmask: 8'h0});
  endtask

  task automatic issue_lsu(input logic [31:0] addr, input logic wen,
                           input logic [31:0] wdata, input logic [7:0] wmask);
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_addr  = addr;
    bus.lsu_req_wen   = wen;
    bus.lsu_req_wdata = wdata;
    bus.lsu_req_wmask = wmask;
    req_q.push_back('{addr: addr, wen: wen, wdata: wdata, wmask: wmask});
  endtask

  // Present a slave response and wait (bounded) for the handshake on the expected master.
  task automatic serve(input logic who, input logic [31:0] rdata, input logic err);
    logic got;
    got = 1'b0;
    resp_q.push_back('{who: who, rdata: rdata, err: err});
    bus.s_resp_rdata = rdata;
    bus.s_resp_err   = err;
    for (int k = 0; k < 20 && !got; k++) begin
      nxt();
      if (who) got = bus.lsu_resp_valid && bus.lsu_resp_ready;
      else     got = bus.ifu_resp_valid && bus.ifu_resp_ready;
      adv();
    end
    chk("resp_within_bound", 32'(got), 32'd1);
  endtask

  task automatic chk_all_quiet(input string tag);
    chk({tag, "_s_req_valid"}, 32'(bus.s_req_valid), 32'd0);
    chk({tag, "_s_resp_ready"}, 32'(bus.s_resp_ready), 32'd0);
    chk({tag, "_ifu_req_ready"}, 32'(bus.ifu_req_ready), 32'd0);
    chk({tag, "_lsu_req_ready"}, 32'(bus.lsu_req_ready), 32'd0);
    chk({tag, "_ifu_resp_valid"}, 32'(bus.ifu_resp_valid), 32'd0);
    chk({tag, "_lsu_resp_valid"}, 32'(bus.lsu_resp_valid), 32'd0);
    chk({tag, "_s_req_addr"}, bus.s_req_addr, 32'h0);
  endtask

  initial begin : stim
    rst = 1'b1;
    drive_idle();
    nxt();
    chk_all_quiet("reset");
    do_reset();

    // LSU write alone, exact cycle timing.
    issue_lsu(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 8'h0F);
    resp_q.push_back('{who: 1'b1, rdata: 32'h0, err: 1'b0});
    nxt();
    chk("t1_lsu_ready_n", 32'(bus.lsu_req_ready), 32'd1);
    chk("t1_ifu_ready_n", 32'(bus.ifu_req_ready), 32'd0);
    chk("t1_s_valid_n", 32'(bus.s_req_valid), 32'd0);
    adv();
    nxt();
    chk("t1_s_valid_n1", 32'(bus.s_req_valid), 32'd1);
    chk("t1_s_addr_n1", bus.s_req_addr, 32'h8000_0010);
    chk("t1_lsu_ready_n1", 32'(bus.lsu_req_ready), 32'd0);
    adv();
    nxt();
    chk("t1_lsu_resp_n2", 32'(bus.lsu_resp_valid), 32'd1);
    chk("t1_ifu_resp_n2", 32'(bus.ifu_resp_valid), 32'd0);
    chk("t1_s_resp_ready_n2", 32'(bus.s_resp_ready), 32'd1);
    adv();
    nxt();
    chk("t1_s_resp_ready_n3", 32'(bus.s_resp_ready), 32'd0);
    chk("t1_lsu_resp_n3", 32'(bus.lsu_resp_valid), 32'd0);
    chk("t1_s_valid_n3", 32'(bus.s_req_valid), 32'd0);
    adv();

    // Tie from reset: LSU, IFU, then LSU again.
    do_reset();
    issue_lsu(32'h8000_0100, 1'b0, 32'h1111_1111, 8'hFF);
    issue_ifu(32'h8000_0000);
    nxt();
    chk("t2_tie1_lsu_ready", 32'(bus.lsu_req_ready), 32'd1);
    chk("t2_tie1_ifu_ready", 32'(bus.ifu_req_ready), 32'd0);
    adv();
    serve(1'b1, 32'hAAAA_5555, 1'b0);
    nxt();
    chk("t2_ifu_second", 32'(bus.ifu_req_ready), 32'd1);
    adv();
    serve(1'b0, 32'h0000_0413, 1'b0);
    issue_lsu(32'h8000_0104, 1'b0, 32'h0, 8'hFF);
    issue_ifu(32'h8000_0008);
    nxt();
    chk("t2_tie3_lsu_ready", 32'(bus.lsu_req_ready), 32'd1);
    chk("t2_tie3_ifu_ready", 32'(bus.ifu_req_ready), 32'd0);
    adv();
    serve(1'b1, 32'h0000_0022, 1'b0);
    nxt();
    chk("t2_ifu_fourth", 32'(bus.ifu_req_ready), 32'd1);
    adv();
    serve(1'b0, 32'h0000_0033, 1'b0);

    // Back-pressure on both slave request and master response.
    do_reset();
    bus.s_req_ready  = 1'b0;
    bus.s_resp_valid = 1'b0;
    issue_lsu(32'h8000_0040, 1'b1, 32'hCAFE_F00D, 8'hA5);
    issue_ifu(32'h8000_0044);
    nxt();
    chk("t3_lsu_ready", 32'(bus.lsu_req_ready), 32'd1);
    adv();
    bus.lsu_req_addr  = 32'hFFFF_FFF0;
    bus.lsu_req_wdata = 32'h0;
    bus.lsu_req_wmask = 8'h00;
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk("t3_bp_s_valid", 32'(bus.s_req_valid), 32'd1);
      chk("t3_bp_s_addr", bus.s_req_addr, 32'h8000_0040);
      chk("t3_bp_s_wdata", bus.s_req_wdata, 32'hCAFE_F00D);
      chk("t3_bp_s_wmask", 32'(bus.s_req_wmask), 32'h0000_00A5);
      chk("t3_bp_ifu_ready", 32'(bus.ifu_req_ready), 32'd0);
      adv();
    end
    bus.s_req_ready = 1'b1;
    nxt();
    chk("t3_s_valid_accept", 32'(bus.s_req_valid), 32'd1);
    adv();
    bus.s_resp_valid   = 1'b1;
    bus.lsu_resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("t3_rbp_lsu_valid", 32'(bus.lsu_resp_valid), 32'd1);
      chk("t3_rbp_s_resp_ready", 32'(bus.s_resp_ready), 32'd0);
      chk("t3_rbp_ifu_ready", 32'(bus.ifu_req_ready), 32'd0);
      chk("t3_rbp_s_addr", bus.s_req_addr, 32'h8000_0040);
      adv();
    end
    bus.lsu_resp_ready = 1'b1;
    serve(1'b1, 32'h5A5A_0000, 1'b0);
    nxt();
    chk("t3_ifu_after", 32'(bus.ifu_req_ready), 32'd1);
    adv();
    serve(1'b0, 32'h0000_0013, 1'b0);

    // Slave error on a fetch, then a normal LSU access.
    do_reset();
    issue_ifu(32'h0000_0000);
    nxt();
    chk("t4_ifu_ready", 32'(bus.ifu_req_ready), 32'd1);
    adv();
    serve(1'b0, 32'hBAD0_BAD0, 1'b1);
    issue_lsu(32'h8000_0020, 1'b0, 32'h0, 8'hFF);
    nxt();
    chk("t4_lsu_ready_after_err", 32'(bus.lsu_req_ready), 32'd1);
    adv();
    serve(1'b1, 32'h1234_5678, 1'b0);

    // Reset while waiting on the slave response.
    do_reset();
    bus.s_resp_valid = 1'b0;
    issue_ifu(32'h8000_0004);
    nxt();
    adv();
    nxt();
    chk("t5_s_valid", 32'(bus.s_req_valid), 32'd1);
    adv();
    nxt();
    chk("t5_in_resp", 32'(bus.s_resp_ready), 32'd1);
    adv();
    rst = 1'b1;
    nxt();
    adv();
    nxt();
    chk_all_quiet("t5_rst");
    adv();
    rst = 1'b0;
    bus.s_resp_valid = 1'b1;
    issue_lsu(32'h8000_0030, 1'b0, 32'h0, 8'hFF);
    issue_ifu(32'h8000_000C);
    nxt();
    chk("t5_tie_lsu_ready", 32'(bus.lsu_req_ready), 32'd1);
    chk("t5_tie_ifu_ready", 32'(bus.ifu_req_ready), 32'd0);
    adv();
    serve(1'b1, 32'h0000_0044, 1'b0);
    nxt();
    chk("t5_ifu_after", 32'(bus.ifu_req_ready), 32'd1);
    adv();
    serve(1'b0, 32'h0000_0055, 1'b0);

    repeat (2) @(posedge clk);
    chk("req_queue_drained", 32'(req_q.size()), 32'd0);
    chk("resp_queue_drained", 32'(resp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
